// File: rtl/mux_32.sv
// ---------------------------------------------------------------------------
// mux_32 : 32-bit two-way word selector for the CPU next-PC path
//
// Builds z = s ? src1 : src0 from gate primitives, one slice per bit:
//    z[i] = (src0[i] & ~s) | (src1[i] & s)
// and also provides a registered copy z_q for pipelined consumers.
//
// Ports
//    clk   in   1   system clock, z_q updates on the rising edge
//    reset in   1   synchronous active-high reset, clears z_q only
//    sel   in  32   select word (callers drive {31'b0, ctl})
//    src0  in  32   word chosen when the select decision is 0
//    src1  in  32   word chosen when the select decision is 1
//    z     out 32   combinational selected word
//    z_q   out 32   registered copy of z
//
// Build option
//    MUX_32_STRICT_SEL_EN : when defined, the select decision is the
//    OR-reduction of all 32 sel bits, so any nonzero word picks src1.
//    When undefined, only sel[0] matters.
// ---------------------------------------------------------------------------

module and_gate (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a & b;
endmodule

module or_gate (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a | b;
endmodule

module inv_gate (
   input  logic a,
   output logic y
);
   assign y = ~a;
endmodule

module mux_32 (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] sel,
   input  logic [31:0] src0,
   input  logic [31:0] src1,
   output logic [31:0] z,
   output logic [31:0] z_q
);

   logic        s;
   logic        s_n;
   logic [31:0] z_d;

`ifdef MUX_32_STRICT_SEL_EN
   // Balanced OR tree over the whole select word: 16 + 8 + 4 + 2 + 1 gates.
   logic [15:0] or_l1;
   logic [7:0]  or_l2;
   logic [3:0]  or_l3;
   logic [1:0]  or_l4;

   for (genvar k = 0; k < 16; k++) begin : g_or_l1
      or_gate u_or (.a(sel[2*k]),   .b(sel[2*k+1]),   .y(or_l1[k]));
   end
   for (genvar k = 0; k < 8; k++) begin : g_or_l2
      or_gate u_or (.a(or_l1[2*k]), .b(or_l1[2*k+1]), .y(or_l2[k]));
   end
   for (genvar k = 0; k < 4; k++) begin : g_or_l3
      or_gate u_or (.a(or_l2[2*k]), .b(or_l2[2*k+1]), .y(or_l3[k]));
   end
   for (genvar k = 0; k < 2; k++) begin : g_or_l4
      or_gate u_or (.a(or_l3[2*k]), .b(or_l3[2*k+1]), .y(or_l4[k]));
   end
   or_gate u_or_root (.a(or_l4[0]), .b(or_l4[1]), .y(s));
`else
   // Only bit 0 steers the selection; the upper bits are deliberately dropped.
   logic unused_sel_hi;
   assign unused_sel_hi = |sel[31:1];
   assign s             = sel[0];
`endif

   inv_gate u_inv_s (.a(s), .y(s_n));

   // Each bit is an AND-OR slice, so a source that is not selected is
   // gated to 0 and cannot leak X/Z into z while s is known.
   for (genvar i = 0; i < 32; i++) begin : g_bit
      logic pick0;
      logic pick1;

      and_gate u_and0 (.a(src0[i]), .b(s_n), .y(pick0));
      and_gate u_and1 (.a(src1[i]), .b(s),   .y(pick1));
      or_gate  u_or   (.a(pick0),   .b(pick1), .y(z[i]));
   end

   always_comb begin
      z_d = z;
      if (reset) begin
         z_d = 32'h0000_0000;
      end
   end

   always_ff @(posedge clk) begin
      z_q <= z_d;
   end

endmodule

// File: tb/tb_mux_32.sv
module tb_mux_32;

   logic        clk;
   logic        reset;
   logic [31:0] sel;
   logic [31:0] src0;
   logic [31:0] src1;
   logic [31:0] z;
   logic [31:0] z_q;

   int checks;
   int failures;

   mux_32 dut (
      .clk   (clk),
      .reset (reset),
      .sel   (sel),
      .src0  (src0),
      .src1  (src1),
      .z     (z),
      .z_q   (z_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] sel;
      logic [31:0] src0;
      logic [31:0] src1;
      logic [31:0] exp_z;
   } vec_t;

   task automatic check32(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%08h required=%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[$];
   logic [31:0] w;
`ifdef MUX_32_STRICT_SEL_EN
   localparam logic [31:0] UPPER_SEL_EXP = 32'h5555_5555;
`else
   localparam logic [31:0] UPPER_SEL_EXP = 32'hAAAA_AAAA;
`endif

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      sel      = 32'h0;
      src0     = 32'h0;
      src1     = 32'h0;

      vecs.push_back('{"basic_sel1",   32'h1,         32'h0040_0024, 32'h0040_0034, 32'h0040_0034});
      vecs.push_back('{"basic_sel0",   32'h0,         32'h0040_0024, 32'h0040_0034, 32'h0040_0024});
      vecs.push_back('{"equal_sel0",   32'h0,         32'h1357_9BDF, 32'h1357_9BDF, 32'h1357_9BDF});
      vecs.push_back('{"equal_sel1",   32'h1,         32'h1357_9BDF, 32'h1357_9BDF, 32'h1357_9BDF});
      vecs.push_back('{"ones_sel1",    32'h1,         32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
      vecs.push_back('{"zeros_sel1",   32'h1,         32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000});
      vecs.push_back('{"ones_sel0",    32'h0,         32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF});
      vecs.push_back('{"upper_sel",    32'h8000_0000, 32'hAAAA_AAAA, 32'h5555_5555, UPPER_SEL_EXP});
      vecs.push_back('{"sel_odd_bit0", 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'hF0F0_F0F0});

      // Reset held for two edges clears the register
      tick();
      tick();
      check32("reset_zq", z_q, 32'h0);

      // Combinational vectors, applied while reset is still held
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         sel  = vecs[i].sel;
         src0 = vecs[i].src0;
         src1 = vecs[i].src1;
         #1;
         check32(vecs[i].name, z, vecs[i].exp_z);
      end

      // Release: z_q loads z after exactly one edge
      @(negedge clk);
      reset = 1'b0;
      sel   = 32'h1;
      src0  = 32'h0000_0000;
      src1  = 32'hDEAD_BEEF;
      #1;
      check32("zq_before_edge", z_q, 32'h0);
      tick();
      check32("zq_latency", z_q, 32'hDEAD_BEEF);

      // Simultaneous change of all inputs in one cycle
      @(negedge clk);
      sel  = 32'h0;
      src0 = 32'h1234_5678;
      src1 = 32'h0BAD_F00D;
      tick();
      check32("zq_load", z_q, 32'h1234_5678);

      // Reset mid-stream clears z_q while z keeps the selected word
      @(negedge clk);
      reset = 1'b1;
      tick();
      check32("midreset_zq", z_q, 32'h0);
      check32("midreset_z", z, 32'h1234_5678);

      // Release loads the current z on the first edge with reset low
      @(negedge clk);
      reset = 1'b0;
      sel   = 32'h1;
      tick();
      check32("release_zq", z_q, 32'h0BAD_F00D);

      // Walking one on src1
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         w    = 32'h1 << i;
         sel  = 32'h1;
         src0 = 32'h0;
         src1 = w;
         #1;
         check32($sformatf("walk1_bit%0d", i), z, w);
      end

      // Walking zero on src0
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         w    = ~(32'h1 << i);
         sel  = 32'h0;
         src0 = w;
         src1 = 32'hFFFF_FFFF;
         #1;
         check32($sformatf("walk0_bit%0d", i), z, w);
      end

      // X on the unselected source must not reach z
      @(negedge clk);
      sel  = 32'h0;
      src0 = 32'h0000_0004;
      src1 = 32'hxxxx_xxxx;
      #1;
      check32("x_isolation", z, 32'h0000_0004);
      checks++;
      if ($isunknown(z)) begin
         failures++;
         $display("FAIL x_unknown actual=%08h required=no X bits", z);
      end

      // Registered copy follows the last combinational value
      tick();
      check32("x_iso_zq", z_q, 32'h0000_0004);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
